// File: rtl/shift_reg_univ_pkg.sv
// Shared types for the universal shift register and the FSMs that drive it.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package shift_reg_univ_pkg;

  // Operation select as seen on the mode port.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHR  = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_t;

  // True for the two shifting modes, regardless of rotate.
  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

  // A shift brings a new word in only when it is not recirculating one.
  function automatic logic brings_new_word(input mode_t m, input logic rot);
    return is_shift(m) && !rot;
  endfunction

endpackage

// File: rtl/shift_reg_univ_cnt.sv
// Saturating fill counter: number of valid words held, 0..DEPTH, plus full flag.
// Latency: one cycle from clear/inc/load_full to fill_cnt and full.
// Backpressure: none; inc at DEPTH is absorbed by saturation.
import shift_reg_univ_pkg::*;

module shift_reg_univ_cnt #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       inc,
  input  logic                       load_full,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [CW-1:0] cnt_q;
  logic          full_q;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Count, load to DEPTH, or zero; full is registered alongside so it tracks exactly.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (load_full) begin
      cnt_q  <= CNT_MAX;
      full_q <= 1'b1;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q  <= cnt_inc;
      full_q <= (cnt_inc == CNT_MAX);
    end
  end

  assign fill_cnt = cnt_q;
  assign full     = full_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal DEPTH x WIDTH shift register: hold, shift right/left (optional rotate), parallel load.
// Latency: one cycle from any control input to par_out/ser_out_*/fill_cnt; outputs are register-driven.
// Backpressure: none; en gates the operation, any mode sequence is accepted back to back.
import shift_reg_univ_pkg::*;

module shift_reg_univ #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       rotate,
  input  logic [WIDTH-1:0]           ser_in,
  input  logic [DEPTH*WIDTH-1:0]     par_in,
  output logic [DEPTH*WIDTH-1:0]     par_out,
  output logic [WIDTH-1:0]           ser_out_r,
  output logic [WIDTH-1:0]           ser_out_l,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);

  mode_t            mode_e;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] shr_in;
  logic [WIDTH-1:0] shl_in;
  logic             cnt_inc;
  logic             cnt_load;

  assign mode_e = mode_t'(mode);

  // Word entering at the far end: serial input, or the word leaving the other end when rotating.
  assign shr_in = rotate ? stage_q[0]       : ser_in;
  assign shl_in = rotate ? stage_q[DEPTH-1] : ser_in;

  // Next-state for the stage array; hold unless enabled with an active mode.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (en) begin
      case (mode_e)
        MODE_SHR: begin
          for (int k = 0; k < DEPTH - 1; k++) begin
            stage_d[k] = stage_q[k+1];
          end
          stage_d[DEPTH-1] = shr_in;
        end
        MODE_SHL: begin
          for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
          stage_d[0] = shl_in;
        end
        MODE_LOAD: begin
          for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = par_in[k*WIDTH +: WIDTH];
          end
        end
        default: begin
          for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
          end
        end
      endcase
    end
  end

  // Stage registers; reset and clear both zero the contents, reset taking precedence.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Flatten the stage array: stage k occupies bits [k*WIDTH +: WIDTH].
  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign par_out[k*WIDTH +: WIDTH] = stage_q[k];
  end

  // Words that would leave on the next right / left shift.
  assign ser_out_r = stage_q[0];
  assign ser_out_l = stage_q[DEPTH-1];

  // Rotating shifts recirculate existing words, so only plain shifts add to the fill count.
  assign cnt_inc  = en && brings_new_word(mode_e, rotate);
  assign cnt_load = en && (mode_e == MODE_LOAD);

  shift_reg_univ_cnt #(
    .DEPTH(DEPTH)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .inc      (cnt_inc),
    .load_full(cnt_load),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=1, DEPTH=4
  logic       clr_a = 0, en_a = 0, rot_a = 0;
  logic [1:0] mode_a = 0;
  logic [0:0] ser_a = 0;
  logic [3:0] par_a = 0, pout_a;
  logic [0:0] sr_a, sl_a;
  logic [2:0] fc_a;
  logic       full_a;

  // Instance B: WIDTH=8, DEPTH=3
  logic        clr_b = 0, en_b = 0, rot_b = 0;
  logic [1:0]  mode_b = 0;
  logic [7:0]  ser_b = 0;
  logic [23:0] par_b = 0, pout_b;
  logic [7:0]  sr_b, sl_b;
  logic [1:0]  fc_b;
  logic        full_b;

  // Instance C: WIDTH=1, DEPTH=2 (legacy equivalence)
  logic       clr_c = 0, en_c = 0, rot_c = 0;
  logic [1:0] mode_c = 0;
  logic [0:0] ser_c = 0;
  logic [1:0] par_c = 0, pout_c;
  logic [0:0] sr_c, sl_c;
  logic [1:0] fc_c;
  logic       full_c;

  shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clr_a), .en(en_a), .mode(mode_a), .rotate(rot_a),
    .ser_in(ser_a), .par_in(par_a), .par_out(pout_a), .ser_out_r(sr_a), .ser_out_l(sl_a),
    .fill_cnt(fc_a), .full(full_a));

  shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clr_b), .en(en_b), .mode(mode_b), .rotate(rot_b),
    .ser_in(ser_b), .par_in(par_b), .par_out(pout_b), .ser_out_r(sr_b), .ser_out_l(sl_b),
    .fill_cnt(fc_b), .full(full_b));

  shift_reg_univ #(.WIDTH(1), .DEPTH(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clr_c), .en(en_c), .mode(mode_c), .rotate(rot_c),
    .ser_in(ser_c), .par_in(par_c), .par_out(pout_c), .ser_out_r(sr_c), .ser_out_l(sl_c),
    .fill_cnt(fc_c), .full(full_c));

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: the register contents as one integer; shifts are arithmetic on it.
  function automatic logic [63:0] nxt(input logic [63:0] v, input int w, input int d,
                                      input logic [1:0] m, input logic rot,
                                      input logic [63:0] si, input logic [63:0] pi);
    logic [63:0] msk, wm, inw;
    msk = (64'd1 << (w*d)) - 64'd1;
    wm  = (64'd1 << w) - 64'd1;
    inw = '0;
    case (m)
      2'd1: begin
        inw = rot ? (v & wm) : (si & wm);
        return ((v >> w) | (inw << (w*(d-1)))) & msk;
      end
      2'd2: begin
        inw = rot ? ((v >> (w*(d-1))) & wm) : (si & wm);
        return ((v << w) | inw) & msk;
      end
      2'd3: return pi & msk;
      default: return v;
    endcase
  endfunction

  function automatic int nf(input int f, input int d, input logic [1:0] m, input logic rot);
    if (m == 2'd3) return d;
    if ((m == 2'd1 || m == 2'd2) && !rot) return (f < d) ? f + 1 : d;
    return f;
  endfunction

  logic [63:0] mv_a = 0, mv_b = 0, mv_c = 0;
  int          mf_a = 0, mf_b = 0, mf_c = 0;
  logic [1:0]  leg_c = 0;

  always @(posedge clk) begin
    if (!reset_n || clr_a) begin mv_a = 0; mf_a = 0; end
    else if (en_a) begin
      mv_a = nxt(mv_a, 1, 4, mode_a, rot_a, 64'(ser_a), 64'(par_a));
      mf_a = nf(mf_a, 4, mode_a, rot_a);
    end
    if (!reset_n || clr_b) begin mv_b = 0; mf_b = 0; end
    else if (en_b) begin
      mv_b = nxt(mv_b, 8, 3, mode_b, rot_b, 64'(ser_b), 64'(par_b));
      mf_b = nf(mf_b, 3, mode_b, rot_b);
    end
    if (!reset_n || clr_c) begin mv_c = 0; mf_c = 0; leg_c = 0; end
    else if (en_c) begin
      mv_c = nxt(mv_c, 1, 2, mode_c, rot_c, 64'(ser_c), 64'(par_c));
      mf_c = nf(mf_c, 2, mode_c, rot_c);
      leg_c = {ser_c, leg_c[1]};
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_par_out",   64'(pout_a), mv_a);
      chk("a_ser_out_r", 64'(sr_a),   mv_a & 64'h1);
      chk("a_ser_out_l", 64'(sl_a),   (mv_a >> 3) & 64'h1);
      chk("a_fill_cnt",  64'(fc_a),   64'(mf_a));
      chk("a_full",      64'(full_a), 64'(mf_a == 4));
      chk("b_par_out",   64'(pout_b), mv_b);
      chk("b_ser_out_r", 64'(sr_b),   mv_b & 64'hFF);
      chk("b_ser_out_l", 64'(sl_b),   (mv_b >> 16) & 64'hFF);
      chk("b_fill_cnt",  64'(fc_b),   64'(mf_b));
      chk("b_full",      64'(full_b), 64'(mf_b == 3));
      chk("c_par_out",   64'(pout_c), mv_c);
      chk("c_legacy",    64'(pout_c), 64'(leg_c));
      chk("c_fill_cnt",  64'(fc_c),   64'(mf_c));
      chk("c_full",      64'(full_c), 64'(mf_c == 2));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  logic [3:0] exp_fill [4];
  logic [3:0] exp_par  [4];
  logic       seq      [4];

  initial begin
    seq[0] = 1; seq[1] = 0; seq[2] = 1; seq[3] = 1;
    exp_par[0] = 4'b1000; exp_par[1] = 4'b0100; exp_par[2] = 4'b1010; exp_par[3] = 4'b1101;
    exp_fill[0] = 1; exp_fill[1] = 2; exp_fill[2] = 3; exp_fill[3] = 4;

    // Reset held 2 cycles while a load is requested
    reset_n = 0; en_a = 1; mode_a = 3; par_a = 4'hF;
    step(); chk_on = 1; step();
    chk("rst_par", 64'(pout_a), 64'h0);
    chk("rst_fill", 64'(fc_a), 64'h0);
    chk("rst_full", 64'(full_a), 64'h0);

    // Right-shift fill with 1,0,1,1
    reset_n = 1; mode_a = 1; rot_a = 0;
    for (int i = 0; i < 4; i++) begin
      ser_a = seq[i];
      step();
      chk("shr_par", 64'(pout_a), 64'(exp_par[i]));
      chk("shr_fill", 64'(fc_a), 64'(exp_fill[i]));
      chk("shr_full", 64'(full_a), 64'(i == 3));
    end
    ser_a = 0; step();
    chk("shr5_par", 64'(pout_a), 64'h6);
    chk("shr5_fill", 64'(fc_a), 64'h4);

    // Enable gating: en low with toggling ser_in, then mode 0
    en_a = 0;
    for (int i = 0; i < 5; i++) begin ser_a = 1'(i); step(); end
    chk("en0_par", 64'(pout_a), 64'h6);
    chk("en0_fill", 64'(fc_a), 64'h4);
    en_a = 1; mode_a = 0; step(); step();
    chk("hold_par", 64'(pout_a), 64'h6);

    // Clear during a shift
    mode_a = 1; ser_a = 1; clr_a = 1; step();
    chk("clr_par", 64'(pout_a), 64'h0);
    chk("clr_fill", 64'(fc_a), 64'h0);

    // Clear beats a load
    mode_a = 3; par_a = 4'hF; clr_a = 1; step();
    chk("clr_load_par", 64'(pout_a), 64'h0);
    clr_a = 0; step();
    chk("load_par", 64'(pout_a), 64'hF);
    chk("load_full", 64'(full_a), 64'h1);

    // Reset beats clear and en
    reset_n = 0; clr_a = 1; step();
    chk("rst_pri_par", 64'(pout_a), 64'h0);
    chk("rst_pri_fill", 64'(fc_a), 64'h0);
    reset_n = 1; clr_a = 0; en_a = 0; step();

    // WIDTH=8 DEPTH=3: load, rotate left, rotate right
    en_b = 1; mode_b = 3; par_b = 24'hAABBCC; step();
    chk("b_load_sl", 64'(sl_b), 64'hAA);
    chk("b_load_sr", 64'(sr_b), 64'hCC);
    mode_b = 2; rot_b = 1; step();
    chk("b_rotl_par", 64'(pout_b), 64'hBBCCAA);
    chk("b_rotl_fill", 64'(fc_b), 64'h3);
    mode_b = 1; rot_b = 1; step();
    chk("b_rotr_par", 64'(pout_b), 64'hAABBCC);
    clr_b = 1; step(); clr_b = 0;
    mode_b = 2; rot_b = 0; ser_b = 8'h11; step();
    chk("b_shl_par", 64'(pout_b), 64'h000011);
    chk("b_shl_fill", 64'(fc_b), 64'h1);
    mode_b = 1; ser_b = 8'h22; step();
    chk("b_shr_par", 64'(pout_b), 64'h220000);
    mode_b = 3; par_b = 24'h123456; step();
    mode_b = 2; rot_b = 0; ser_b = 8'h77; step();
    chk("b_shl_sat_par", 64'(pout_b), 64'h345677);
    en_b = 0; step();

    // Legacy equivalence: random ser_in/en, mode 1, no rotate
    mode_c = 1; rot_c = 0;
    for (int i = 0; i < 40; i++) begin
      en_c = 1'($urandom_range(0, 1));
      ser_c = 1'($urandom_range(0, 1));
      step();
    end
    en_c = 0; step();

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
